// File: rtl/qsys_ledr_sequencer.sv
// rtl/qsys_ledr_sequencer.sv - LEDR PIO pattern sequencer with Avalon-MM control slave
module qsys_ledr_sequencer #(
    parameter int LED_WIDTH = 10,
    parameter int DEPTH     = 8,
    parameter int PERIOD_W  = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  ctrl_address,
    input  logic        ctrl_chipselect,
    input  logic        ctrl_write_n,
    input  logic [31:0] ctrl_writedata,
    output logic [31:0] ctrl_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT, DONE} state_t;

    state_t                state, state_next;
    logic                  en, loop_mode, done_flag;
    logic [PERIOD_W-1:0]   period, cnt, cnt_next;
    logic [3:0]            length, eff_len;
    logic [2:0]            idx, idx_next, pat_idx;
    logic [LED_WIDTH-1:0]  pat [DEPTH];
    logic                  ctrl_wr, pat_sel, en_eff, last_idx, set_done, start;
    logic                  unused_wdata;

    assign ctrl_wr      = ctrl_chipselect && !ctrl_write_n;
    assign pat_sel      = (int'(ctrl_address) >= 8) && (int'(ctrl_address) < 8 + DEPTH);
    assign pat_idx      = ctrl_address[2:0];
    assign unused_wdata = ^ctrl_writedata;
    assign pio_address  = 2'b00;
    assign busy         = (state != IDLE);

    // A CTRL write landing this cycle already counts, so a disable stops the next write.
    assign en_eff = (ctrl_wr && ctrl_address == 4'd0) ? ctrl_writedata[0] : en;

    always_comb begin
        if (length == 4'd0)
            eff_len = 4'd1;
        else if (int'(length) > DEPTH)
            eff_len = 4'(DEPTH);
        else
            eff_len = length;
    end

    assign last_idx = ({1'b0, idx} == eff_len - 4'd1);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        set_done   = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = WRITE;
                    idx_next   = 3'd0;
                    start      = 1'b1;
                end
            end
            WRITE: begin
                if (!en_eff) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT;
                    cnt_next   = period;
                end
            end
            WAIT: begin
                if (!en_eff) begin
                    state_next = IDLE;
                end else if (cnt != '0) begin
                    cnt_next = cnt - PERIOD_W'(1);
                end else if (!last_idx) begin
                    idx_next   = idx + 3'd1;
                    state_next = WRITE;
                end else if (loop_mode) begin
                    idx_next   = 3'd0;
                    state_next = WRITE;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                set_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes are registered off the next state so the PIO write coincides with WRITE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            idx            <= 3'd0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            idx            <= idx_next;
            pio_chipselect <= (state_next == WRITE);
            pio_write_n    <= (state_next != WRITE);
            if (state_next == WRITE)
                pio_writedata <= {{(32-LED_WIDTH){1'b0}}, pat[idx_next]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            en        <= 1'b0;
            loop_mode <= 1'b0;
            period    <= '0;
            length    <= 4'd1;
            done_flag <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                pat[i] <= '0;
        end else begin
            if (ctrl_wr) begin
                case (ctrl_address)
                    4'd0: begin
                        en        <= ctrl_writedata[0];
                        loop_mode <= ctrl_writedata[1];
                    end
                    4'd1: period <= ctrl_writedata[PERIOD_W-1:0];
                    4'd2: length <= ctrl_writedata[3:0];
                    default: begin
                        if (pat_sel)
                            pat[pat_idx] <= ctrl_writedata[LED_WIDTH-1:0];
                    end
                endcase
            end
            if (set_done)
                en <= 1'b0;
            if (set_done)
                done_flag <= 1'b1;
            else if (start)
                done_flag <= 1'b0;
            else if (ctrl_wr && ctrl_address == 4'd3 && ctrl_writedata[8])
                done_flag <= 1'b0;
        end
    end

    always_comb begin
        ctrl_readdata = '0;
        case (ctrl_address)
            4'd0: ctrl_readdata = {30'b0, loop_mode, en};
            4'd1: ctrl_readdata[PERIOD_W-1:0] = period;
            4'd2: ctrl_readdata[3:0] = length;
            4'd3: ctrl_readdata = {23'b0, done_flag, 1'b0, idx, 3'b0, busy};
            default: begin
                if (pat_sel)
                    ctrl_readdata[LED_WIDTH-1:0] = pat[pat_idx];
            end
        endcase
    end

endmodule

// File: tb/tb_qsys_ledr_sequencer.sv
// tb/tb_qsys_ledr_sequencer.sv - self-checking bench for qsys_ledr_sequencer
module tb_qsys_ledr_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  ctrl_address;
    logic        ctrl_chipselect;
    logic        ctrl_write_n;
    logic [31:0] ctrl_writedata;
    logic [31:0] ctrl_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        busy;

    always #5 clk = ~clk;

    qsys_ledr_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .ctrl_address(ctrl_address), .ctrl_chipselect(ctrl_chipselect),
        .ctrl_write_n(ctrl_write_n), .ctrl_writedata(ctrl_writedata),
        .ctrl_readdata(ctrl_readdata),
        .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
        .busy(busy)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    bit mvalid = 0;

    // Model: register file plus a timeline of the next write / decision / done cycle.
    bit          m_en, m_loop, m_done, m_run;
    logic [23:0] m_period;
    logic [3:0]  m_length;
    logic [9:0]  m_pat [8];
    int          m_idx;
    logic [31:0] m_led;
    int          m_next_wr, m_dec_cyc, m_done_cyc;

    int          log_t[$];
    logic [31:0] log_d[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit exp_busy();
        return m_run || (cyc == m_done_cyc);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        logic [2:0] i3;
        i3 = m_idx[2:0];
        case (a)
            4'd0: return {30'b0, m_loop, m_en};
            4'd1: return {8'b0, m_period};
            4'd2: return {28'b0, m_length};
            4'd3: return {23'b0, m_done, 1'b0, i3, 3'b0, exp_busy()};
            default: return (a >= 4'd8) ? {22'b0, m_pat[a[2:0]]} : 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_loop = 0; m_done = 0; m_run = 0;
        m_period = '0; m_length = 4'd1; m_idx = 0; m_led = '0;
        m_next_wr = -10; m_dec_cyc = -10; m_done_cyc = -10;
        for (int i = 0; i < 8; i++) m_pat[i] = '0;
    endtask

    task automatic model_step();
        bit wr, en_eff, clr_done;
        int len;
        if (reset_n !== 1'b1) begin
            model_reset();
            mvalid = 1;
            return;
        end
        if (!mvalid) return;
        wr = ctrl_chipselect && !ctrl_write_n;
        en_eff = (wr && ctrl_address == 4'd0) ? ctrl_writedata[0] : m_en;
        clr_done = 0;
        len = (m_length == 0) ? 1 : ((m_length > 8) ? 8 : int'(m_length));
        if (cyc == m_done_cyc) begin
        end else if (!m_run) begin
            if (m_en) begin
                m_run = 1; m_idx = 0; m_next_wr = cyc + 1;
                m_led = {22'b0, m_pat[0]}; clr_done = 1;
            end
        end else if (!en_eff) begin
            m_run = 0;
        end else if (cyc == m_next_wr) begin
            m_dec_cyc = cyc + int'(m_period) + 1;
        end else if (cyc == m_dec_cyc) begin
            if (m_idx < len - 1) begin
                m_idx++; m_next_wr = cyc + 1; m_led = {22'b0, m_pat[m_idx]};
            end else if (m_loop) begin
                m_idx = 0; m_next_wr = cyc + 1; m_led = {22'b0, m_pat[0]};
            end else begin
                m_run = 0; m_done_cyc = cyc + 1;
            end
        end
        if (wr) begin
            case (ctrl_address)
                4'd0: begin m_en = ctrl_writedata[0]; m_loop = ctrl_writedata[1]; end
                4'd1: m_period = ctrl_writedata[23:0];
                4'd2: m_length = ctrl_writedata[3:0];
                4'd3: if (ctrl_writedata[8]) m_done = 0;
                default: if (ctrl_address >= 4'd8) m_pat[ctrl_address[2:0]] = ctrl_writedata[9:0];
            endcase
        end
        if (clr_done) m_done = 0;
        if (cyc == m_done_cyc) begin
            m_done = 1; m_en = 0;
        end
    endtask

    initial begin
        bit e_cs;
        forever begin
            @(negedge clk);
            if (mvalid) begin
                e_cs = m_run && (cyc == m_next_wr);
                check("pio_chipselect", pio_chipselect, e_cs);
                check("pio_write_n", pio_write_n, !e_cs);
                check("pio_writedata", pio_writedata, m_led);
                check("pio_address", pio_address, 0);
                check("busy", busy, exp_busy());
                check("ctrl_readdata", ctrl_readdata, exp_rd(ctrl_address));
            end
            if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
                log_t.push_back(cyc);
                log_d.push_back(pio_writedata);
            end
            model_step();
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        ctrl_address = a; ctrl_writedata = d;
        ctrl_chipselect = 1; ctrl_write_n = 0;
        tick();
        ctrl_chipselect = 0; ctrl_write_n = 1;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
        ctrl_address = a;
        #1;
        check(name, ctrl_readdata, exp);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (3) tick();
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", busy, 0);
    endtask

    task automatic wait_write();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (pio_chipselect === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("wait_write_timeout", ok, 1);
    endtask

    task automatic clear_log();
        log_t.delete();
        log_d.delete();
    endtask

    initial begin
        logic [31:0] exp8 [8];
        exp8 = '{32'h001, 32'h002, 32'h3ff, 32'h008, 32'h010, 32'h020, 32'h040, 32'h200};

        reset_n = 0; ctrl_chipselect = 0; ctrl_write_n = 1;
        ctrl_address = 0; ctrl_writedata = 0;
        tick();
        ctrl_chipselect = 1; ctrl_write_n = 0; ctrl_writedata = 32'h3;
        repeat (3) tick();
        reset_n = 1; ctrl_chipselect = 0; ctrl_write_n = 1; ctrl_writedata = 0;
        check("reset_no_write", log_d.size(), 0);
        rd(4'd3, 32'h0, "reset_status");
        rd(4'd2, 32'h1, "reset_length");
        rd(4'd0, 32'h0, "reset_ctrl");

        // One-shot of three patterns, PERIOD=4
        cpu_write(4'd8, 32'h001); cpu_write(4'd9, 32'h002); cpu_write(4'd10, 32'h3ff);
        cpu_write(4'd2, 32'd3); cpu_write(4'd1, 32'd4);
        clear_log();
        cpu_write(4'd0, 32'h1);
        wait_idle(200);
        check("oneshot_count", log_d.size(), 3);
        if (log_d.size() >= 3) begin
            check("oneshot_d0", log_d[0], 32'h001);
            check("oneshot_d1", log_d[1], 32'h002);
            check("oneshot_d2", log_d[2], 32'h3ff);
            check("oneshot_gap", log_t[1] - log_t[0], 6);
            check("oneshot_gap2", log_t[2] - log_t[1], 6);
        end
        rd(4'd3, 32'h120, "oneshot_status");
        rd(4'd0, 32'h0, "oneshot_ctrl");

        // Loop, disable during WAIT
        cpu_write(4'd2, 32'd2); cpu_write(4'd1, 32'd0);
        clear_log();
        cpu_write(4'd0, 32'h3);
        wait_write(); tick();
        wait_write(); tick();
        wait_write(); tick();
        cpu_write(4'd0, 32'h0);
        repeat (6) tick();
        check("loop_count", log_d.size(), 3);
        if (log_d.size() >= 3) begin
            check("loop_d0", log_d[0], 32'h001);
            check("loop_d1", log_d[1], 32'h002);
            check("loop_d2", log_d[2], 32'h001);
            check("loop_gap", log_t[1] - log_t[0], 2);
        end

        // Disable coinciding with the second WRITE
        clear_log();
        cpu_write(4'd0, 32'h3);
        wait_write(); tick();
        wait_write();
        cpu_write(4'd0, 32'h0);
        repeat (6) tick();
        check("dis_write_count", log_d.size(), 2);
        rd(4'd3, 32'h10, "dis_write_status");

        // LENGTH=0 behaves as one entry
        cpu_write(4'd2, 32'd0); cpu_write(4'd1, 32'd1);
        clear_log();
        cpu_write(4'd0, 32'h1);
        wait_idle(100);
        check("len0_count", log_d.size(), 1);
        if (log_d.size() >= 1) check("len0_d0", log_d[0], 32'h001);
        rd(4'd3, 32'h100, "len0_status");

        // LENGTH=15 clamps to the table depth
        cpu_write(4'd11, 32'h008); cpu_write(4'd12, 32'h010); cpu_write(4'd13, 32'h020);
        cpu_write(4'd14, 32'h040); cpu_write(4'd15, 32'h200);
        cpu_write(4'd2, 32'd15); cpu_write(4'd1, 32'd0);
        clear_log();
        cpu_write(4'd0, 32'h1);
        wait_idle(200);
        check("len15_count", log_d.size(), 8);
        if (log_d.size() >= 8)
            for (int i = 0; i < 8; i++) check($sformatf("len15_d%0d", i), log_d[i], exp8[i]);
        rd(4'd3, 32'h170, "len15_status");

        // DONE W1C landing in the DONE cycle
        cpu_write(4'd2, 32'd1); cpu_write(4'd1, 32'd0);
        cpu_write(4'd0, 32'h1);
        wait_write(); tick(); tick();
        check("done_cycle_busy", busy, 1);
        cpu_write(4'd3, 32'h100);
        rd(4'd3, 32'h100, "w1c_set_wins");
        cpu_write(4'd3, 32'h100);
        rd(4'd3, 32'h0, "w1c_clears");

        // PAT1 rewritten while idx=0
        cpu_write(4'd2, 32'd2); cpu_write(4'd1, 32'd6);
        clear_log();
        cpu_write(4'd0, 32'h1);
        wait_write(); tick();
        cpu_write(4'd9, 32'h155);
        wait_idle(100);
        check("patrw_count", log_d.size(), 2);
        if (log_d.size() >= 2) begin
            check("patrw_d0", log_d[0], 32'h001);
            check("patrw_d1", log_d[1], 32'h155);
        end

        // Unmapped write ignored
        cpu_write(4'd5, 32'hffff);
        rd(4'd5, 32'h0, "unmapped_read");

        // Reset in a WRITE cycle
        cpu_write(4'd2, 32'd2); cpu_write(4'd1, 32'd3);
        cpu_write(4'd0, 32'h3);
        wait_write();
        reset_n = 0;
        tick();
        check("midrun_cs", pio_chipselect, 0);
        check("midrun_wn", pio_write_n, 1);
        check("midrun_busy", busy, 0);
        reset_n = 1;
        rd(4'd3, 32'h0, "midrun_status");
        rd(4'd0, 32'h0, "midrun_ctrl");
        rd(4'd1, 32'h0, "midrun_period");
        rd(4'd2, 32'h1, "midrun_length");
        rd(4'd9, 32'h0, "midrun_pat1");
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/qsys_ledr_sequencer.md
Name: qsys_ledr_sequencer

Overview:
- Pattern sequencer that drives the LEDR PIO slave.
- Holds a small CPU-programmable pattern table and steps through it.
- Issues single-cycle Avalon-MM writes to the PIO data register at a programmable period, in one-shot or loop mode.
- Sits between the Nios control slave fabric and the LEDR PIO s1 port, so the CPU does not have to bit-bang LED animations.

Parameters:
LED_WIDTH, 10, width of the pattern and of the PIO output port
DEPTH, 8, pattern table entries (power of two, max 8)
PERIOD_W, 24, width of the period counter

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
ctrl_address  in  4  control slave word address
ctrl_chipselect  in  1  control slave select
ctrl_write_n  in  1  control slave write strobe, active-low
ctrl_writedata  in  32  control slave write data
ctrl_readdata  out  32  control slave read data, combinational
pio_address  out  2  PIO s1 address, always 0
pio_chipselect  out  1  PIO s1 chipselect, registered
pio_write_n  out  1  PIO s1 write strobe, active-low, registered
pio_writedata  out  32  PIO s1 write data, registered
busy  out  1  high while the sequencer is not IDLE

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is synchronous and active-low, sampled on the rising edge of clk.
- Register map, word addresses. A control write is `ctrl_chipselect && !ctrl_write_n`.
  - 0 CTRL: bit0 EN, bit1 LOOP.
  - 1 PERIOD: bits PERIOD_W-1:0.
  - 2 LENGTH: bits 3:0.
  - 3 STATUS: bit0 busy (RO); bits 6:4 idx (RO); bit8 DONE (W1C).
  - 8..8+DEPTH-1 PAT[n]: bits LED_WIDTH-1:0.
  - Unmapped addresses read 0; writes to them are ignored.
- ctrl_readdata is combinational from ctrl_address. Unused bits read 0.
- Reset state:
  - EN=0, LOOP=0, PERIOD=0, LENGTH=1, DONE=0, idx=0, all PAT=0, state IDLE.
  - pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, busy=0.
- Effective length L:
  - LENGTH=0 is treated as 1.
  - LENGTH>DEPTH is clamped to DEPTH.
  - L is sampled at each index-advance decision.
- FSM states: IDLE, WRITE, WAIT, DONE.
  - IDLE: no PIO access. If EN=1, go to WRITE with idx=0 and clear DONE.
  - WRITE: exactly one cycle with pio_chipselect=1, pio_write_n=0, pio_writedata={zero-ext, PAT[idx]}. Load cnt=PERIOD, then go to WAIT.
  - WAIT: if EN=0, go to IDLE. Else if cnt!=0, decrement cnt. Else (cnt=0) advance:
    - idx<L-1: idx+1, go to WRITE.
    - idx=L-1 and LOOP=1: idx=0, go to WRITE.
    - idx=L-1 and LOOP=0: go to DONE.
  - DONE: one cycle. Set DONE=1, clear EN, go to IDLE.
- Strobe outputs are registered: the PIO sees the write in the cycle the FSM is in WRITE. Outside WRITE, pio_chipselect=0 and pio_write_n=1.
- Write spacing: consecutive PIO writes are exactly PERIOD+2 clocks apart. PERIOD=0 gives 2 clocks.
- The last pattern stays on the LEDs after DONE or disable; the sequencer never blanks the LEDs.
- Simultaneous events:
  - A CTRL write with EN=0 in the WRITE cycle does not suppress that PIO write; the next state is IDLE.
  - EN written to 1 while already running: no restart, idx is unchanged.
  - DONE W1C in the same cycle DONE is set: the set wins.
  - PAT[n] written during a run takes effect the next time idx=n is written out.
  - LOOP changes take effect at the next wrap decision.
  - PERIOD changes take effect at the next WRITE.
- Counter: cnt is PERIOD_W bits, decrements only in WAIT, never wraps below 0.
- Reset mid-run: returns to the reset state on the next edge. The strobe deasserts in that cycle, with no partial write.

Test Plan:
- Reset check: hold reset_n=0 for 3 clocks with writes attempted → STATUS=0, LENGTH=1, pio_write_n=1 throughout, no PIO write.
- One-shot: PAT0..2 = 0x001, 0x002, 0x3FF; LENGTH=3; PERIOD=4; CTRL=0x1 → exactly 3 PIO writes with data 0x001, 0x002, 0x3FF, spaced 6 clocks apart. Then DONE=1, EN reads 0, busy=0.
- Loop and disable: LENGTH=2, PERIOD=0, CTRL=0x3 → writes alternate PAT0, PAT1, PAT0 every 2 clocks. Writing CTRL=0 during WAIT stops writes immediately. Writing CTRL=0 coinciding with a WRITE cycle → that one write completes, then none.
- Boundary: LENGTH=0 → single write of PAT0, then DONE. LENGTH=15 → 8 writes (PAT0..PAT7), then DONE.
- Collisions: DONE W1C in the DONE cycle → DONE reads 1. Rewrite PAT1=0x155 while idx=0 → second write carries 0x155.
- Reset mid-run: assert reset_n=0 in a WRITE cycle → pio_chipselect=0 next edge, state IDLE, all registers at reset values.
